// File: rtl/move_input_ctrl.sv
// rtl/move_input_ctrl.sv - debounced cursor and move-request front-end for the tic-tac-toe controller
// Five raw buttons are synchronized, debounced and edge-detected before driving the cursor and move FSM.
module move_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACK_TIMEOUT     = 8
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic        btnLeft,
  input  logic        btnRight,
  input  logic        btnSelect,
  input  logic [17:0] gBoard,
  input  logic [1:0]  winner,
  output logic        playerWrite,
  output logic [3:0]  playerInput,
  output logic [3:0]  cursor,
  output logic        moveRejected,
  output logic        busy
);

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CYCLES);
  localparam logic [7:0] ACK_INIT = 8'(ACK_TIMEOUT);

  // Button bit order: 0 select, 1 up, 2 down, 3 left, 4 right.
  localparam int B_SEL   = 0;
  localparam int B_UP    = 1;
  localparam int B_DOWN  = 2;
  localparam int B_LEFT  = 3;
  localparam int B_RIGHT = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [4:0]      raw;
  logic [4:0]      sync1_q, sync1_d;
  logic [4:0]      sync2_q, sync2_d;
  logic [4:0]      level_q, level_d;
  logic [4:0]      level_prev_q, level_prev_d;
  logic [4:0]      rise_q, rise_d;
  logic [4:0][3:0] cnt_q, cnt_d;

  state_t          state_q, state_d;
  logic [3:0]      cursor_q, cursor_d;
  logic [3:0]      pinput_q, pinput_d;
  logic            pwrite_q, pwrite_d;
  logic            reject_q, reject_d;
  logic            busy_q, busy_d;
  logic [7:0]      timer_q, timer_d;

  assign raw = {btnRight, btnLeft, btnDown, btnUp, btnSelect};

  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    case (idx)
      4'd0:    cell_at = b[1:0];
      4'd1:    cell_at = b[3:2];
      4'd2:    cell_at = b[5:4];
      4'd3:    cell_at = b[7:6];
      4'd4:    cell_at = b[9:8];
      4'd5:    cell_at = b[11:10];
      4'd6:    cell_at = b[13:12];
      4'd7:    cell_at = b[15:14];
      4'd8:    cell_at = b[17:16];
      default: cell_at = 2'b00;
    endcase
  endfunction

  function automatic logic col_first(input logic [3:0] c);
    col_first = (c == 4'd0) || (c == 4'd3) || (c == 4'd6);
  endfunction

  function automatic logic col_last(input logic [3:0] c);
    col_last = (c == 4'd2) || (c == 4'd5) || (c == 4'd8);
  endfunction

  // Debounce: a level flips only after DB_LIMIT consecutive disagreeing samples.
  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    level_prev_d = level_q;
    rise_d       = level_q & ~level_prev_q;
    cnt_d        = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = 4'd0;
      end else if (cnt_q[i] + 4'd1 == DB_LIMIT) begin
        level_d[i] = ~level_q[i];
        cnt_d[i]   = 4'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    pinput_d = pinput_q;
    pwrite_d = 1'b0;
    reject_d = 1'b0;
    busy_d   = busy_q;
    timer_d  = timer_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (rise_q[B_SEL]) begin
          if ((winner != 2'b00) || (cell_at(gBoard, cursor_q) != 2'b00)) begin
            reject_d = 1'b1;
          end else begin
            pinput_d = cursor_q;
            pwrite_d = 1'b1;
            busy_d   = 1'b1;
            state_d  = S_WRITE;
          end
        end else if (rise_q[B_UP]) begin
          cursor_d = (cursor_q < 4'd3) ? cursor_q + 4'd6 : cursor_q - 4'd3;
        end else if (rise_q[B_DOWN]) begin
          cursor_d = (cursor_q >= 4'd6) ? cursor_q - 4'd6 : cursor_q + 4'd3;
        end else if (rise_q[B_LEFT]) begin
          cursor_d = col_first(cursor_q) ? cursor_q + 4'd2 : cursor_q - 4'd1;
        end else if (rise_q[B_RIGHT]) begin
          cursor_d = col_last(cursor_q) ? cursor_q - 4'd2 : cursor_q + 4'd1;
        end
      end
      S_WRITE: begin
        busy_d  = 1'b1;
        timer_d = ACK_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Exit on the board showing the cell, or when the timer runs out; no retry.
        busy_d  = 1'b1;
        timer_d = timer_q - 8'd1;
        if ((cell_at(gBoard, pinput_q) != 2'b00) || (timer_q <= 8'd1)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      level_prev_q <= '0;
      rise_q       <= '0;
      cnt_q        <= '0;
      state_q      <= S_IDLE;
      cursor_q     <= 4'd4;
      pinput_q     <= 4'd0;
      pwrite_q     <= 1'b0;
      reject_q     <= 1'b0;
      busy_q       <= 1'b0;
      timer_q      <= 8'd0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      rise_q       <= rise_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      pinput_q     <= pinput_d;
      pwrite_q     <= pwrite_d;
      reject_q     <= reject_d;
      busy_q       <= busy_d;
      timer_q      <= timer_d;
    end
  end

  assign playerWrite  = pwrite_q;
  assign playerInput  = pinput_q;
  assign cursor       = cursor_q;
  assign moveRejected = reject_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// tb/tb_move_input_ctrl.sv - directed and randomized checks of move_input_ctrl against a grid/move model
module tb_move_input_ctrl;
  localparam int D   = 4;
  localparam int ACK = 8;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        btnUp, btnDown, btnLeft, btnRight, btnSelect;
  logic [17:0] gBoard;
  logic [1:0]  winner;
  logic        playerWrite;
  logic [3:0]  playerInput;
  logic [3:0]  cursor;
  logic        moveRejected;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int model_cursor;
  int last_pin;
  int wcnt, wk, pin, bcnt, rcnt, rk;

  always #5 ph1 = ~ph1;

  move_input_ctrl #(.DEBOUNCE_CYCLES(D), .ACK_TIMEOUT(ACK)) dut (
    .ph1(ph1), .reset(reset),
    .btnUp(btnUp), .btnDown(btnDown), .btnLeft(btnLeft), .btnRight(btnRight), .btnSelect(btnSelect),
    .gBoard(gBoard), .winner(winner),
    .playerWrite(playerWrite), .playerInput(playerInput), .cursor(cursor),
    .moveRejected(moveRejected), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  // mask bits: 0 select, 1 up, 2 down, 3 left, 4 right
  task automatic drive(input logic [4:0] m);
    {btnRight, btnLeft, btnDown, btnUp, btnSelect} = m;
  endtask

  // Grid model: row/col arithmetic modulo 3.
  function automatic int mv(input int c, input int dir);
    int r, k;
    r = c / 3;
    k = c % 3;
    case (dir)
      1: r = (r + 2) % 3;
      2: r = (r + 1) % 3;
      3: k = (k + 2) % 3;
      4: k = (k + 1) % 3;
      default: ;
    endcase
    return r * 3 + k;
  endfunction

  function automatic int apply_mask(input int c, input logic [4:0] m);
    for (int d = 1; d <= 4; d++)
      if (m[d]) return mv(c, d);
    return c;
  endfunction

  task automatic press_dir(input logic [4:0] m, input string tag);
    drive(m);
    repeat (D + 3) tick();
    drive(5'b0);
    repeat (D + 6) tick();
    model_cursor = apply_mask(model_cursor, m);
    check(tag, cursor, model_cursor);
  endtask

  task automatic goto_cell(input int t);
    int guard;
    guard = 0;
    while ((model_cursor / 3 != t / 3) && guard < 4) begin
      press_dir(5'b00100, "goto_down");
      guard++;
    end
    while ((model_cursor % 3 != t % 3) && guard < 8) begin
      press_dir(5'b10000, "goto_right");
      guard++;
    end
    check("goto_reached", cursor, t);
  endtask

  task automatic run_select(input int ack_delay, input bit right_in_wait);
    wcnt = 0; wk = -1; pin = -1; bcnt = 0; rcnt = 0; rk = -1;
    drive(5'b00001);
    for (int k = 0; k < 45; k++) begin
      tick();
      if (k == D + 2) btnSelect = 1'b0;
      if (playerWrite === 1'b1) begin
        wcnt++;
        wk = k;
        pin = int'(playerInput);
      end
      if (busy === 1'b1) bcnt++;
      if (moveRejected === 1'b1) begin
        rcnt++;
        rk = k;
      end
      if (ack_delay > 0 && wk >= 0 && pin >= 0 && pin <= 8 && k == wk + ack_delay)
        gBoard[2*pin +: 2] = 2'b11;
      if (right_in_wait && wk >= 0 && k == wk + 1) btnRight = 1'b1;
      if (right_in_wait && wk >= 0 && k == wk + 1 + D + 3) btnRight = 1'b0;
    end
    drive(5'b0);
  endtask

  initial begin
    logic [4:0] m;
    logic [1:0] v;
    int t, d, exp_busy;
    bit rej, done;

    reset = 1'b1;
    drive(5'b0);
    gBoard = '0;
    winner = 2'b00;
    repeat (3) tick();
    check("rst_cursor", cursor, 4);
    check("rst_pwrite", playerWrite, 0);
    check("rst_pinput", playerInput, 0);
    check("rst_reject", moveRejected, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    model_cursor = 4;
    last_pin = 0;

    // Held Right: one move at D+3 edges, nothing more while held.
    drive(5'b10000);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("right_hold", cursor, (k >= D + 3) ? 5 : 4);
    end
    drive(5'b0);
    repeat (D + 6) tick();
    model_cursor = 5;

    // Bouncing Up never stays stable long enough.
    for (int k = 0; k < 30; k++) begin
      btnUp = ((k / 2) % 2) == 0;
      tick();
      check("bounce_up", cursor, model_cursor);
    end
    drive(5'b0);
    repeat (D + 6) tick();
    check("bounce_final", cursor, model_cursor);

    goto_cell(2);
    press_dir(5'b10000, "wrap_right");
    check("wrap_2_right", cursor, 0);
    press_dir(5'b00010, "wrap_up");
    check("wrap_0_up", cursor, 6);
    press_dir(5'b00100, "wrap_down");
    check("wrap_6_down", cursor, 0);
    goto_cell(3);
    press_dir(5'b01000, "wrap_left");
    check("wrap_3_left", cursor, 5);

    // Random simultaneous direction presses exercise priority and wrap.
    repeat (24) begin
      m = {4'($urandom_range(0, 15)), 1'b0};
      if (m == 5'b0) m = 5'b10000;
      press_dir(m, "rand_dir");
    end

    // Accepted move with ack three cycles after the write.
    goto_cell(4);
    gBoard = '0;
    winner = 2'b00;
    run_select(3, 1'b0);
    check("acc_wcnt", wcnt, 1);
    check("acc_wlat", wk, D + 3);
    check("acc_pin", pin, 4);
    check("acc_busy", bcnt, 4);
    check("acc_rcnt", rcnt, 0);
    last_pin = 4;

    // Occupied cell rejection.
    gBoard = '0;
    gBoard[9:8] = 2'b10;
    run_select(0, 1'b0);
    check("occ_rcnt", rcnt, 1);
    check("occ_rlat", rk, D + 3);
    check("occ_wcnt", wcnt, 0);
    check("occ_busy", bcnt, 0);
    check("occ_pin_hold", playerInput, last_pin);

    // Game-over rejection.
    gBoard = '0;
    winner = 2'b01;
    run_select(0, 1'b0);
    check("over_rcnt", rcnt, 1);
    check("over_wcnt", wcnt, 0);
    check("over_busy", bcnt, 0);
    winner = 2'b00;

    // Timeout with a Right press landing during WAIT.
    gBoard = '0;
    run_select(0, 1'b1);
    check("to_wcnt", wcnt, 1);
    check("to_busy", bcnt, ACK + 1);
    check("to_cursor", cursor, model_cursor);
    last_pin = model_cursor;

    // Random boards, winners and ack delays.
    repeat (8) begin
      t = $urandom_range(0, 8);
      goto_cell(t);
      for (int i = 0; i < 9; i++) begin
        v = 2'($urandom_range(1, 3));
        gBoard[2*i +: 2] = ($urandom_range(0, 1) == 0) ? 2'b00 : v;
      end
      v = 2'($urandom_range(1, 3));
      winner = ($urandom_range(0, 3) == 0) ? v : 2'b00;
      d = $urandom_range(0, 9);
      rej = (winner != 2'b00) || (gBoard[2*t +: 2] != 2'b00);
      exp_busy = (d == 0 || d > ACK) ? ACK + 1 : d + 1;
      run_select(d, 1'b0);
      if (rej) begin
        check("rnd_rej_rcnt", rcnt, 1);
        check("rnd_rej_wcnt", wcnt, 0);
        check("rnd_rej_busy", bcnt, 0);
        check("rnd_rej_pin", playerInput, last_pin);
      end else begin
        check("rnd_acc_wcnt", wcnt, 1);
        check("rnd_acc_rcnt", rcnt, 0);
        check("rnd_acc_pin", pin, t);
        check("rnd_acc_busy", bcnt, exp_busy);
        last_pin = t;
      end
      winner = 2'b00;
    end

    // Reset in the middle of WAIT.
    gBoard = '0;
    goto_cell(0);
    done = 1'b0;
    wk = -1;
    drive(5'b00001);
    for (int k = 0; k < 30 && !done; k++) begin
      tick();
      if (k == D + 2) btnSelect = 1'b0;
      if (playerWrite === 1'b1) wk = k;
      if (wk >= 0 && k == wk + 3) begin
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cursor", cursor, 4);
        check("mid_rst_pwrite", playerWrite, 0);
        check("mid_rst_pinput", playerInput, 0);
        done = 1'b1;
      end
    end
    check("mid_wait_reached", done, 1);
    drive(5'b0);

    // Button held through reset release must debounce afresh.
    btnRight = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < D + 6; k++) begin
      tick();
      check("held_thru_rst", cursor, (k >= D + 3) ? 5 : 4);
    end
    drive(5'b0);
    repeat (D + 6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
